mem_bus_sequencer: RTL and testbench
====================================

// Module: mem_bus_sequencer
// PURPOSE
//  Shares the single external memory bus (MREQ/WRITE/SIZE/address/DDT/ACK_n) between the
//  instruction-fetch requester and the data load/store requester of the multicycle datapath.
//  Arbitrates, registers the bus cycle, waits for the active-low ACK_n, and returns data/done.
//  Aborts with bus_err if ACK_n never arrives. Sits between ctrl_datapath and the top-level pins.
// PARAMETERS
//  AW        32  address width
//  DW        32  data width
//  TIMEOUT   15  max wait cycles for ACK_n before abort (>=1)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  if_req     in   1   fetch request; held high until if_done
//  if_addr    in   AW  fetch address
//  if_done    out  1   1-cycle pulse: fetch finished (data or error)
//  if_rdata   out  DW  fetched instruction, valid with if_done, held until next fetch done
//  d_req      in   1   data request; held high until d_done
//  d_we       in   1   1=store, 0=load
//  d_size     in   2   access size, passed to SIZE
//  d_addr     in   AW  data address
//  d_wdata    in   DW  store data
//  d_done     out  1   1-cycle pulse: data access finished
//  d_rdata    out  DW  load data, valid with d_done, held until next load done
//  bus_err    out  1   1-cycle pulse with *_done when the access timed out
//  MREQ       out  1   bus cycle active
//  WRITE      out  1   bus cycle is a store
//  SIZE       out  2   bus access size (fetch always 2'b00 = word)
//  ADR        out  AW  bus address
//  DDT_o      out  DW  write data to bus
//  DDT_oe     out  1   tri-state enable for DDT (= MREQ & WRITE)
//  DDT_i      in   DW  read data from bus
//  ACK_n      in   1   active-low acknowledge, sampled on rising clk while MREQ=1
// BEHAVIOUR
//  - Reset (async, rst=0): state=IDLE; MREQ, WRITE, DDT_oe, if_done, d_done, bus_err = 0;
//    SIZE=0, ADR=0, DDT_o=0, if_rdata=0, d_rdata=0, wait counter=0, last_grant=FETCH.
//    Reset mid-access drops MREQ immediately; the pending access is lost, no done pulse.
//  - States: IDLE, FETCH, DATA, FIN.
//  - IDLE: if no request, stay. If exactly one request, grant it. If both, grant the
//    requester NOT in last_grant (alternation). On grant, register ADR/SIZE/WRITE/DDT_o
//    from the winner, set MREQ=1, clear counter, go to FETCH or DATA, update last_grant.
//    Bus outputs are therefore valid the cycle after req is first seen high.
//  - FETCH/DATA: ADR/SIZE/WRITE/DDT_o stable while MREQ=1. Each edge with ACK_n=0:
//    capture DDT_i into if_rdata (FETCH) or d_rdata (DATA load; stores leave d_rdata),
//    drop MREQ/WRITE, pulse matching *_done next cycle, go to FIN.
//    ACK_n=1: counter++; when counter reaches TIMEOUT, drop MREQ, pulse *_done and bus_err,
//    rdata unchanged, go to FIN.
//  - FIN: one idle turnaround cycle (MREQ=0); *_done is high during this cycle; back to IDLE.
//    Min latency req->done: 3 cycles (grant, ACK on first bus cycle, FIN).
//  - ACK_n while MREQ=0 is ignored. Requester dropping req mid-access is ignored; the
//    access completes. Counter is $clog2(TIMEOUT+1) bits, never wraps (cleared on grant).
//  - Back-to-back: a requester still high in IDLE after FIN is re-arbitrated normally.
// TESTING
//  1 Fetch only: if_addr=0x100, ACK_n low 2nd bus cycle, DDT_i=0xDEADBEEF -> MREQ=1 ADR=0x100
//    WRITE=0 SIZE=0 for 2 cycles; if_done 1 pulse, if_rdata=0xDEADBEEF, bus_err=0.
//  2 Store: d_we=1 d_addr=0x2000 d_wdata=0x12345678 d_size=2'b10, ACK first cycle ->
//    DDT_oe=1 DDT_o=0x12345678 WRITE=1 SIZE=2'b10 1 cycle; d_done pulse; d_rdata unchanged.
//  3 Simultaneous if_req and d_req after reset -> DATA granted first (last_grant=FETCH),
//    then FETCH; hold both high 4 accesses -> grants strictly alternate D,F,D,F.
//  4 Timeout: d_req load, ACK_n held 1 -> MREQ high exactly 15 cycles, then d_done+bus_err
//    same cycle, d_rdata unchanged, next request served normally.
//  5 Reset mid-access: assert rst=0 during FETCH -> MREQ=0 same cycle, no if_done; after
//    release, pending if_req re-issued from IDLE with MREQ one cycle later.
//  6 Spurious ACK_n=0 in IDLE/FIN -> no done pulse, no rdata change.

Source files
------------

// File: rtl/mem_bus_sequencer_if.sv
// Request/response and external memory bus signals of mem_bus_sequencer.
// master: the sequencer side. slave: the requesters plus the memory/pins side.
interface mem_bus_sequencer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          bus_err;
  logic          MREQ;
  logic          WRITE;
  logic [1:0]    SIZE;
  logic [AW-1:0] ADR;
  logic [DW-1:0] DDT_o;
  logic          DDT_oe;
  logic [DW-1:0] DDT_i;
  logic          ACK_n;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, DDT_i, ACK_n,
    output if_done, if_rdata, d_done, d_rdata, bus_err,
    output MREQ, WRITE, SIZE, ADR, DDT_o, DDT_oe
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, DDT_i, ACK_n,
    input  if_done, if_rdata, d_done, d_rdata, bus_err,
    input  MREQ, WRITE, SIZE, ADR, DDT_o, DDT_oe
  );
endinterface

// File: rtl/mem_bus_sequencer.sv
// Shares one external memory bus between instruction fetch and data load/store,
// alternating on contention, with an ACK_n timeout that aborts the access with bus_err.
module mem_bus_sequencer #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input logic clk,
  input logic rst_n,
  mem_bus_sequencer_if.master bus_io
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StData, StFin} state_e;

  state_e        state_q, state_d;
  logic          mreq_q, mreq_d;
  logic          write_q, write_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] ddt_o_q, ddt_o_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;
  logic          bus_err_q, bus_err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          last_data_q, last_data_d;

  always_comb begin
    state_d     = state_q;
    mreq_d      = mreq_q;
    write_d     = write_q;
    size_d      = size_q;
    adr_d       = adr_q;
    ddt_o_d     = ddt_o_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    bus_err_d   = 1'b0;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;

    unique case (state_q)
      StIdle: begin
        // On contention the requester that did not win last time gets the bus.
        if (bus_io.d_req && (!bus_io.if_req || !last_data_q)) begin
          state_d     = StData;
          mreq_d      = 1'b1;
          write_d     = bus_io.d_we;
          size_d      = bus_io.d_size;
          adr_d       = bus_io.d_addr;
          ddt_o_d     = bus_io.d_wdata;
          cnt_d       = '0;
          last_data_d = 1'b1;
        end else if (bus_io.if_req) begin
          state_d     = StFetch;
          mreq_d      = 1'b1;
          write_d     = 1'b0;
          size_d      = 2'b00;
          adr_d       = bus_io.if_addr;
          ddt_o_d     = '0;
          cnt_d       = '0;
          last_data_d = 1'b0;
        end
      end
      StFetch, StData: begin
        if (!bus_io.ACK_n) begin
          if (state_q == StFetch) begin
            if_rdata_d = bus_io.DDT_i;
          end else if (!write_q) begin
            d_rdata_d = bus_io.DDT_i;
          end
          mreq_d    = 1'b0;
          write_d   = 1'b0;
          if_done_d = (state_q == StFetch);
          d_done_d  = (state_q == StData);
          state_d   = StFin;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(TIMEOUT - 1)) begin
            mreq_d    = 1'b0;
            write_d   = 1'b0;
            if_done_d = (state_q == StFetch);
            d_done_d  = (state_q == StData);
            bus_err_d = 1'b1;
            state_d   = StFin;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mreq_q      <= 1'b0;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      adr_q       <= '0;
      ddt_o_q     <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      cnt_q       <= '0;
      last_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mreq_q      <= mreq_d;
      write_q     <= write_d;
      size_q      <= size_d;
      adr_q       <= adr_d;
      ddt_o_q     <= ddt_o_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
    end
  end

  assign bus_io.MREQ     = mreq_q;
  assign bus_io.WRITE    = write_q;
  assign bus_io.SIZE     = size_q;
  assign bus_io.ADR      = adr_q;
  assign bus_io.DDT_o    = ddt_o_q;
  assign bus_io.DDT_oe   = mreq_q & write_q;
  assign bus_io.if_rdata = if_rdata_q;
  assign bus_io.d_rdata  = d_rdata_q;
  assign bus_io.if_done  = if_done_q;
  assign bus_io.d_done   = d_done_q;
  assign bus_io.bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Bench for mem_bus_sequencer: table of single accesses with a response scoreboard,
// plus arbitration, reset-abort and spurious-ACK sequences.
module tb_mem_bus_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_bus_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  mem_bus_sequencer #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  typedef struct {
    bit          is_data;
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;  // bus cycle with ACK_n=0; 0 = never
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    bit          is_data;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  logic [31:0] m_if_rdata, m_d_rdata;
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic idle_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_size  = 2'b00;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.DDT_i   = '0;
    bus.ACK_n   = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", {29'd0, bus.MREQ, bus.WRITE, bus.DDT_oe}, 32'd0);
    chk("rst_done", {29'd0, bus.if_done, bus.d_done, bus.bus_err}, 32'd0);
    chk("rst_size", {30'd0, bus.SIZE}, 32'd0);
    chk("rst_adr", bus.ADR, 32'd0);
    chk("rst_ddt_o", bus.DDT_o, 32'd0);
    chk("rst_rdata", bus.if_rdata | bus.d_rdata, 32'd0);
    m_if_rdata = '0;
    m_d_rdata  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int bc, exp_bc;
    bit seen;
    string tg;
    tg = $sformatf("v%0d", idx);
    bus.if_req  = !v.is_data;
    bus.if_addr = v.addr;
    bus.d_req   = v.is_data;
    bus.d_we    = v.we;
    bus.d_size  = v.size;
    bus.d_addr  = v.addr;
    bus.d_wdata = v.wdata;
    bus.ACK_n   = 1'b1;
    e.is_data = v.is_data;
    e.err     = (v.ack_at == 0 || v.ack_at > TO);
    if (!e.err && !(v.is_data && v.we)) begin
      if (v.is_data) m_d_rdata = v.rdata;
      else m_if_rdata = v.rdata;
    end
    e.rdata = v.is_data ? m_d_rdata : m_if_rdata;
    sb.push_back(e);
    exp_bc = e.err ? TO : v.ack_at;
    bc = 0;
    seen = 0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      @(negedge clk);
      if (bus.MREQ) begin
        bc++;
        chk({tg, "_adr"}, bus.ADR, v.addr);
        if (bc == 1) begin
          chk({tg, "_write"}, {31'd0, bus.WRITE}, {31'd0, v.is_data & v.we});
          chk({tg, "_size"}, {30'd0, bus.SIZE}, {30'd0, v.is_data ? v.size : 2'b00});
          chk({tg, "_oe"}, {31'd0, bus.DDT_oe}, {31'd0, v.is_data & v.we});
          if (v.is_data && v.we) chk({tg, "_ddt_o"}, bus.DDT_o, v.wdata);
        end
        bus.ACK_n = (bc == v.ack_at) ? 1'b0 : 1'b1;
        bus.DDT_i = (bc == v.ack_at) ? v.rdata : ~v.rdata;
      end else begin
        bus.ACK_n = 1'b1;
      end
      if (bus.if_done || bus.d_done) begin
        seen = 1;
        e = sb.pop_front();
        chk({tg, "_which_done"}, {30'd0, bus.if_done, bus.d_done},
            e.is_data ? 32'd1 : 32'd2);
        chk({tg, "_bus_err"}, {31'd0, bus.bus_err}, {31'd0, e.err});
        chk({tg, "_rdata"}, e.is_data ? bus.d_rdata : bus.if_rdata, e.rdata);
        chk({tg, "_other_rdata"}, e.is_data ? bus.if_rdata : bus.d_rdata,
            e.is_data ? m_if_rdata : m_d_rdata);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
      end
    end
    if (!seen) begin
      bound_fail({tg, "_done"});
      void'(sb.pop_front());
    end
    chk({tg, "_mreq_cycles"}, bc, exp_bc);
    @(negedge clk);
    chk({tg, "_pulse_end"}, {29'd0, bus.if_done, bus.d_done, bus.bus_err}, 32'd0);
  endtask

  vec_t vecs[7];
  int ndone;
  bit seen;

  initial begin
    idle_inputs();
    m_if_rdata = '0;
    m_d_rdata  = '0;
    vecs[0] = '{0, 0, 2'b00, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1, 2'b10, 32'h0000_2000, 32'h1234_5678, 1, 32'hFFFF_0000};
    vecs[2] = '{1, 0, 2'b01, 32'h0000_3004, 32'h0, 1, 32'hCAFE_F00D};
    vecs[3] = '{1, 0, 2'b00, 32'h0000_5000, 32'h0, 0, 32'h1111_2222};
    vecs[4] = '{1, 0, 2'b10, 32'h0000_0040, 32'h0, 3, 32'h0BAD_F00D};
    vecs[5] = '{0, 0, 2'b00, 32'h0000_0204, 32'h0, 0, 32'h3333_4444};
    vecs[6] = '{0, 0, 2'b00, 32'h0000_0208, 32'h0, TO, 32'h55AA_55AA};

    #2;
    do_reset();
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Both requesters held: after reset data wins first, then strict alternation.
    do_reset();
    begin
      exp_t x;
      for (int i = 0; i < 4; i++) begin
        x.is_data = (i % 2 == 0);
        x.err     = 1'b0;
        x.rdata   = x.is_data ? 32'h21 : 32'h11;
        sb.push_back(x);
      end
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h10;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h20;
      ndone = 0;
      for (int cyc = 0; cyc < 60 && ndone < 4; cyc++) begin
        @(negedge clk);
        bus.ACK_n = !bus.MREQ;
        bus.DDT_i = bus.ADR + 32'd1;
        if (bus.if_done || bus.d_done) begin
          x = sb.pop_front();
          chk($sformatf("alt%0d_grant", ndone), {30'd0, bus.if_done, bus.d_done},
              x.is_data ? 32'd1 : 32'd2);
          chk($sformatf("alt%0d_rdata", ndone), x.is_data ? bus.d_rdata : bus.if_rdata,
              x.rdata);
          ndone++;
          if (ndone == 4) begin
            bus.if_req = 1'b0;
            bus.d_req  = 1'b0;
          end
        end
      end
      chk("alt_count", ndone, 4);
      bus.ACK_n = 1'b1;
      m_if_rdata = 32'h11;
      m_d_rdata  = 32'h21;
    end

    // Reset during a fetch drops MREQ at once; the held request restarts afterwards.
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    bus.ACK_n   = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 5 && !seen; cyc++) begin
      @(negedge clk);
      seen = bus.MREQ;
    end
    if (!seen) bound_fail("rstmid_mreq");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_mreq_drop", {30'd0, bus.MREQ, bus.DDT_oe}, 32'd0);
    chk("rstmid_no_done", {31'd0, bus.if_done}, 32'd0);
    m_if_rdata = '0;
    m_d_rdata  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstmid_release_idle", {31'd0, bus.MREQ}, 32'd0);
    @(negedge clk);
    chk("rstmid_regrant", {31'd0, bus.MREQ}, 32'd1);
    chk("rstmid_adr", bus.ADR, 32'h300);
    bus.ACK_n = 1'b0;
    bus.DDT_i = 32'h77;
    @(negedge clk);
    chk("rstmid_done", {31'd0, bus.if_done}, 32'd1);
    chk("rstmid_rdata", bus.if_rdata, 32'h77);
    bus.if_req = 1'b0;
    bus.ACK_n  = 1'b1;
    m_if_rdata = 32'h77;
    @(negedge clk);

    // ACK_n low while idle must do nothing.
    bus.ACK_n = 1'b0;
    bus.DDT_i = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("spur_idle%0d_done", i), {30'd0, bus.if_done, bus.d_done}, 32'd0);
      chk($sformatf("spur_idle%0d_rdata", i), bus.if_rdata ^ bus.d_rdata,
          m_if_rdata ^ m_d_rdata);
    end

    // ACK_n left low through FIN and the following idle cycles.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h400;
    bus.DDT_i   = 32'h600D_CAFE;
    seen = 0;
    for (int cyc = 0; cyc < 6 && !seen; cyc++) begin
      @(negedge clk);
      if (bus.if_done) begin
        seen = 1;
        bus.if_req = 1'b0;
        bus.DDT_i  = 32'hBAD1_BAD1;
      end
    end
    if (!seen) bound_fail("spur_fin_done");
    chk("spur_fin_rdata", bus.if_rdata, 32'h600D_CAFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("spur_fin%0d_done", i), {30'd0, bus.if_done, bus.MREQ}, 32'd0);
      chk($sformatf("spur_fin%0d_rdata", i), bus.if_rdata, 32'h600D_CAFE);
    end
    bus.ACK_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
